// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane-banked data memory.
// byte_en spans two words so that a word-crossing access yields low and high lane enables.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } dmem_size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } dmem_state_e;

  localparam int unsigned MAX_NB = 8;

  // Bits [nb-1:0] address word w, bits [2*nb-1:nb] spill into word w+1.
  function automatic logic [2*MAX_NB-1:0] byte_en(input logic [1:0] size,
                                                  input logic [2:0] off,
                                                  input int unsigned nb);
    logic [3:0]          bytes;
    logic [2*MAX_NB-1:0] m;
    bytes = 4'd1 << size;
    m = ((16'd1 << bytes) - 16'd1) << off;
    m = m & ((16'd1 << (2 * nb)) - 16'd1);
    return m;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] data,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic [63:0] r;
    case (size)
      SZ_B:    r = {{56{~is_unsigned & data[7]}},  data[7:0]};
      SZ_H:    r = {{48{~is_unsigned & data[15]}}, data[15:0]};
      SZ_W:    r = {{32{~is_unsigned & data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_ram_bank.sv
// One byte lane: 8-bit wide single-port block RAM, registered read (read-first).
// One cycle read latency, no backpressure; contents are neither reset nor initialised.
module dmem_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/dmem_lane_ram.sv
// Byte-lane-banked data memory: aligned/extended loads, masked stores, 1-cycle response (2 when split).
// Ready drops only in SPLIT; no response backpressure. DMEM_MISALIGN_EN enables splitting crossing accesses.
module dmem_lane_ram
  import dmem_pkg::*;
#(
  parameter int DMEM_DEPTH      = 1024,
  parameter int DATA_WIDTH      = 32,
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0]                 req_size_i,
  input  logic                       req_unsigned_i,
  input  logic [DATA_WIDTH-1:0]      req_wdata_i,
  output logic                       rsp_valid_o,
  output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
  output logic                       rsp_err_o
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OW  = $clog2(NB);
  localparam int WW  = DMEM_ADDR_WIDTH - OW;
  localparam int BEW = 2 * NB;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_dw_check
    $error("dmem_lane_ram: DATA_WIDTH must be 32 or 64");
  end
  if (DMEM_ADDR_WIDTH != $clog2(DMEM_DEPTH * NB)) begin : g_aw_check
    $error("dmem_lane_ram: DMEM_ADDR_WIDTH must equal clog2(DMEM_DEPTH*NB)");
  end

  dmem_state_e state_q, state_d;

  logic [OW-1:0]         req_off;
  logic [WW-1:0]         req_word;
  logic [BEW-1:0]        req_be;
  logic [DATA_WIDTH-1:0] req_wdata_lo;
  logic                  req_cross;
  logic                  req_size_ill;

  logic                  accept;
  logic                  rsp_fire;
  logic                  rsp_err_d;

  logic [WW-1:0]         bank_addr;
  logic [NB-1:0]         bank_we;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [DATA_WIDTH-1:0] bank_rdata;

  logic [OW-1:0]         p_off;
  logic [1:0]            p_size;
  logic                  p_uns;
  logic                  p_load;
  logic                  p_err;
  logic                  rsp_vld_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] rsp_word;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign req_off      = req_addr_i[OW-1:0];
  assign req_word     = req_addr_i[DMEM_ADDR_WIDTH-1:OW];
  assign req_be       = BEW'(byte_en(req_size_i, 3'(req_off), NB));
  assign req_cross    = |req_be[BEW-1:NB];
  assign req_size_ill = (DATA_WIDTH == 32) && (req_size_i == SZ_D);
  assign req_wdata_lo = req_wdata_i << (8 * req_off);

`ifdef DMEM_MISALIGN_EN
  logic [DATA_WIDTH-1:0] req_wdata_hi;
  logic [WW-1:0]         split_word_q;
  logic [NB-1:0]         split_be_q;
  logic [DATA_WIDTH-1:0] split_wdata_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  p_split;

  // Bytes shifted out of the low word; an offset of 0 shifts everything out.
  assign req_wdata_hi = req_wdata_i >> (DATA_WIDTH - 8 * req_off);
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    accept      = 1'b0;
    rsp_fire    = 1'b0;
    rsp_err_d   = 1'b0;
    bank_addr   = req_word;
    bank_we     = '0;
    bank_wdata  = req_wdata_lo;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept = 1'b1;
          if (req_size_ill) begin
            rsp_fire  = 1'b1;
            rsp_err_d = 1'b1;
          end else if (req_cross) begin
`ifdef DMEM_MISALIGN_EN
            bank_we = req_we_i ? req_be[NB-1:0] : '0;
            state_d = SPLIT;
`else
            rsp_fire  = 1'b1;
            rsp_err_d = 1'b1;
`endif
          end else begin
            bank_we  = req_we_i ? req_be[NB-1:0] : '0;
            rsp_fire = 1'b1;
          end
        end
      end
`ifdef DMEM_MISALIGN_EN
      SPLIT: begin
        bank_addr  = split_word_q;
        bank_we    = split_be_q;
        bank_wdata = split_wdata_q;
        rsp_fire   = 1'b1;
        state_d    = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    dmem_bank #(
      .DEPTH (DMEM_DEPTH),
      .AW    (WW)
    ) u_bank (
      .clk_i   (clk_i),
      .we_i    (bank_we[i]),
      .addr_i  (bank_addr),
      .wdata_i (bank_wdata[8*i +: 8]),
      .rdata_o (bank_rdata[8*i +: 8])
    );
  end

  // Request attributes are captured at accept; err/valid only change on the edge that completes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_off     <= '0;
      p_size    <= '0;
      p_uns     <= 1'b0;
      p_load    <= 1'b0;
      p_err     <= 1'b0;
      rsp_vld_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      if (accept) begin
        p_off  <= req_off;
        p_size <= req_size_i;
        p_uns  <= req_unsigned_i;
        p_load <= !req_we_i;
      end
      if (rsp_fire) p_err <= rsp_err_d;
      rsp_vld_q <= rsp_fire;
      if (rsp_vld_q) hold_q <= rsp_data;
    end
  end

`ifdef DMEM_MISALIGN_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      split_word_q  <= '0;
      split_be_q    <= '0;
      split_wdata_q <= '0;
      lo_q          <= '0;
      p_split       <= 1'b0;
    end else begin
      if (accept && req_cross) begin
        split_word_q  <= (req_word == WW'(DMEM_DEPTH - 1)) ? '0 : req_word + 1'b1;
        split_be_q    <= req_we_i ? req_be[BEW-1:NB] : '0;
        split_wdata_q <= req_wdata_hi;
      end
      // Bank output still holds word w during SPLIT; it is overwritten by word w+1 at this edge.
      if (state_q == SPLIT) lo_q <= bank_rdata;
      if (rsp_fire) p_split <= (state_q == SPLIT);
    end
  end

  assign rsp_word = DATA_WIDTH'({(p_split ? bank_rdata : {DATA_WIDTH{1'b0}}),
                                 (p_split ? lo_q : bank_rdata)} >> (8 * p_off));
`else
  assign rsp_word = bank_rdata >> (8 * p_off);
`endif

  assign rsp_data    = (p_load && !p_err) ?
                       DATA_WIDTH'(load_extend(64'(rsp_word), p_size, p_uns)) : '0;
  assign rsp_valid_o = rsp_vld_q;
  assign rsp_rdata_o = rsp_vld_q ? rsp_data : hold_q;
  assign rsp_err_o   = p_err;

endmodule

// File: tb/tb_dmem_lane_ram.sv
// Directed bench for dmem_lane_ram (DATA_WIDTH 32); expectations follow DMEM_MISALIGN_EN when defined.
module tb_dmem_lane_ram;

`ifdef DMEM_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [11:0] req_addr_i = '0;
  logic [1:0]  req_size_i = '0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dmem_lane_ram #(
    .DMEM_DEPTH      (1024),
    .DATA_WIDTH      (32),
    .DMEM_ADDR_WIDTH (12)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [11:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_addr_i     = addr;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_wdata_i    = wdata;
  endtask

  // Issue one request while idle and wait (bounded) for its response pulse.
  task automatic do_req(input logic we, input logic [11:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic rdy1);
    @(negedge clk_i);
    drive(we, addr, size, uns, wdata);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rdy1 = req_ready_o;
    lat  = 1;
    while (!rsp_valid_o && lat < 8) begin
      @(negedge clk_i);
      lat++;
    end
    rdata = rsp_rdata_o;
    err   = rsp_err_o;
  endtask

  task automatic ld(input string tag, input logic [11:0] addr, input logic [1:0] size,
                    input logic uns, input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    logic [31:0] d;
    logic        e;
    logic        r;
    int          l;
    do_req(1'b0, addr, size, uns, 32'h0, d, e, l, r);
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_err"}, 32'(e), 32'(exp_e));
    chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
  endtask

  task automatic st(input string tag, input logic [11:0] addr, input logic [1:0] size,
                    input logic [31:0] wdata, input logic exp_e, input int exp_lat);
    logic [31:0] d;
    logic        e;
    logic        r;
    int          l;
    do_req(1'b1, addr, size, 1'b0, wdata, d, e, l, r);
    chk({tag, "_data"}, d, 32'h0);
    chk({tag, "_err"}, 32'(e), 32'(exp_e));
    chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic        r;
    logic        saw;
    int          l;

    repeat (2) @(negedge clk_i);
    chk("rst_vld", 32'(rsp_valid_o), 32'h0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    chk("rst_err", 32'(rsp_err_o), 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'h1);

    // Aligned word, byte store, extension of bytes and halves.
    st("sw010", 12'h010, 2'd2, 32'hDEADBEEF, 1'b0, 1);
    ld("lw010", 12'h010, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 1);
    @(negedge clk_i);
    chk("vld_pulse", 32'(rsp_valid_o), 32'h0);
    repeat (2) @(negedge clk_i);
    chk("hold_rdata", rsp_rdata_o, 32'hDEADBEEF);
    st("sb013", 12'h013, 2'd0, 32'h00000080, 1'b0, 1);
    ld("lb013", 12'h013, 2'd0, 1'b0, 32'hFFFFFF80, 1'b0, 1);
    ld("lbu013", 12'h013, 2'd0, 1'b1, 32'h00000080, 1'b0, 1);
    ld("lw010b", 12'h010, 2'd2, 1'b0, 32'h80ADBEEF, 1'b0, 1);
    ld("lh011", 12'h011, 2'd1, 1'b0, 32'hFFFFADBE, 1'b0, 1);
    ld("lhu012", 12'h012, 2'd1, 1'b1, 32'h000080AD, 1'b0, 1);
    ld("lh012", 12'h012, 2'd1, 1'b0, 32'hFFFF80AD, 1'b0, 1);

    // Word-crossing load and store.
    st("sw014", 12'h014, 2'd2, 32'h11223344, 1'b0, 1);
    do_req(1'b0, 12'h012, 2'd2, 1'b0, 32'h0, d, e, l, r);
    chk("xlw012_data", d, MIS ? 32'h334480AD : 32'h0);
    chk("xlw012_err", 32'(e), MIS ? 32'h0 : 32'h1);
    chk("xlw012_lat", 32'(l), MIS ? 32'd2 : 32'd1);
    chk("xlw012_rdy", 32'(r), MIS ? 32'h0 : 32'h1);
    st("xsw012", 12'h012, 2'd2, 32'hCAFEF00D, !MIS, MIS ? 2 : 1);
    repeat (2) @(negedge clk_i);
    chk("err_hold", 32'(rsp_err_o), MIS ? 32'h0 : 32'h1);
    ld("lw010c", 12'h010, 2'd2, 1'b0, MIS ? 32'hF00DBEEF : 32'h80ADBEEF, 1'b0, 1);
    ld("lw014", 12'h014, 2'd2, 1'b0, MIS ? 32'h1122CAFE : 32'h11223344, 1'b0, 1);

    // Store then load of the same byte on consecutive cycles.
    @(negedge clk_i);
    drive(1'b1, 12'h016, 2'd0, 1'b0, 32'h00000077);
    @(negedge clk_i);
    drive(1'b0, 12'h016, 2'd0, 1'b1, 32'h0);
    chk("b2b_st_vld", 32'(rsp_valid_o), 32'h1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("b2b_ld_vld", 32'(rsp_valid_o), 32'h1);
    chk("b2b_ld_data", rsp_rdata_o, 32'h00000077);
    ld("lw014b", 12'h014, 2'd2, 1'b0, MIS ? 32'h1177CAFE : 32'h11773344, 1'b0, 1);

    // Illegal dword size on a 32-bit memory.
    st("sw018", 12'h018, 2'd2, 32'h55667788, 1'b0, 1);
    ld("ld010", 12'h010, 2'd3, 1'b0, 32'h0, 1'b1, 1);
    st("sd018", 12'h018, 2'd3, 32'hFFFFFFFF, 1'b1, 1);
    ld("lw018", 12'h018, 2'd2, 1'b0, 32'h55667788, 1'b0, 1);

    // Half store crossing the top of memory wraps to word 0.
    st("swffc", 12'hFFC, 2'd2, 32'h01020304, 1'b0, 1);
    st("sw000", 12'h000, 2'd2, 32'h0A0B0C0D, 1'b0, 1);
    st("xshfff", 12'hFFF, 2'd1, 32'h0000A55A, !MIS, MIS ? 2 : 1);
    ld("lbufff", 12'hFFF, 2'd0, 1'b1, MIS ? 32'h0000005A : 32'h00000001, 1'b0, 1);
    ld("lbu000", 12'h000, 2'd0, 1'b1, MIS ? 32'h000000A5 : 32'h0000000D, 1'b0, 1);
    ld("xlhufff", 12'hFFF, 2'd1, 1'b1, MIS ? 32'h0000A55A : 32'h0, !MIS, MIS ? 2 : 1);
    ld("lwffc", 12'hFFC, 2'd2, 1'b0, MIS ? 32'h5A020304 : 32'h01020304, 1'b0, 1);
    ld("lw000", 12'h000, 2'd2, 1'b0, MIS ? 32'h0A0B0CA5 : 32'h0A0B0C0D, 1'b0, 1);

    // Reset while the second half of a crossing store is pending.
    st("sw020", 12'h020, 2'd2, 32'h0, 1'b0, 1);
    st("sw024", 12'h024, 2'd2, 32'h0, 1'b0, 1);
    @(negedge clk_i);
    drive(1'b1, 12'h022, 2'd2, 1'b0, 32'hCAFEF00D);
    @(posedge clk_i);
    #1;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    saw         = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      if (rsp_valid_o) saw = 1'b1;
    end
    rst_ni = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      if (rsp_valid_o) saw = 1'b1;
    end
    chk("rsplit_norsp", 32'(saw), 32'h0);
    chk("rsplit_ready", 32'(req_ready_o), 32'h1);
    chk("rsplit_rdata", rsp_rdata_o, 32'h0);
    ld("rsplit_lw020", 12'h020, 2'd2, 1'b0, MIS ? 32'hF00D0000 : 32'h0, 1'b0, 1);
    ld("rsplit_lw024", 12'h024, 2'd2, 1'b0, 32'h0, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lane_ram.md
# dmem_lane_ram

Parametrised, byte-lane-banked data memory with a valid/ready request port, a registered response port, and load alignment with sign/zero extension. It sits between the core's memory stage and block RAM, and is the generalised successor of the fixed 32-bit four-bank data memory. It supports data widths of 32 or 64 bits and optionally splits word-crossing accesses into two array cycles.

## Interface
- DMEM_DEPTH, 1024, depth in data words.
- DATA_WIDTH, 32, word width in bits; 32 or 64. Lanes `NB = DATA_WIDTH/8`.
- DMEM_ADDR_WIDTH, 12, byte-address width; must equal `$clog2(DMEM_DEPTH*NB)` (elaboration assertion).
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted on `valid && ready`.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  DMEM_ADDR_WIDTH  byte address.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword. 3 is legal only when DATA_WIDTH = 64.
- req_unsigned_i  in  1  zero-extend the load when 1; sign-extend when 0.
- req_wdata_i  in  DATA_WIDTH  store data, LSB-aligned.
- rsp_valid_o  out  1  one-cycle response pulse for every accepted request.
- rsp_rdata_o  out  DATA_WIDTH  load result, LSB-aligned and extended; 0 for stores.
- rsp_err_o  out  1  illegal size, or a crossing access when the split feature is absent.

## Operation
- Offset `off = addr[log2(NB)-1:0]`; word index `w = addr[AW-1:log2(NB)]`; `bytes = 1<<size`.
- An access is crossing when `off + bytes > NB`. A non-crossing access at any offset (e.g. a half at offset 1) completes in a single cycle.
- Stores:
  - Byte enable = `((1<<bytes)-1) << off`.
  - Lane data = `wdata << (8*off)`.
  - Only enabled lanes are written.
- Loads: the whole word is read, shifted right by `8*off`, masked to `bytes`, and sign- or zero-extended to DATA_WIDTH.
- FSM states IDLE and SPLIT:
  - IDLE: `req_ready_o = 1`.
    - Non-crossing accept: one array access, stay in IDLE.
    - Crossing accept: access word w (low part), capture the partial data or remaining enables, go to SPLIT.
  - SPLIT: `req_ready_o = 0`. Access word `w+1` (high part), go to IDLE.
- Word index `w+1` wraps modulo DMEM_DEPTH: top word wraps to word 0.
- Illegal size (3 with DATA_WIDTH = 32):
  - No write; rdata 0; `rsp_err_o = 1`.
  - Single-cycle latency.
- Memory contents are not reset and not initialised.
- There is no response backpressure; the consumer always takes the response.

## Timing
- Reset values: `req_ready_o = 1` after release, `rsp_valid_o = 0`, `rsp_rdata_o = 0`, `rsp_err_o = 0`, state IDLE.
- Non-crossing request accepted at edge E0: array access at E0; response valid in the cycle after E0. Throughput is one per cycle.
- Crossing request accepted at E0: second access at E1; response valid in the cycle after E1. The next accept is possible at E2 at the earliest.
- A load issued the cycle after a store to the same bytes returns the new data.
- `rsp_rdata_o` and `rsp_err_o` hold their values between responses.
- `rst_ni` asserted in SPLIT aborts the access:
  - The first-half store is already committed; the second half is not written.
  - No response is produced.
  - State returns to IDLE.

## Configuration
- `DMEM_MISALIGN_EN` defined: crossing accesses are split as described above, with `rsp_err_o = 0`.
- `DMEM_MISALIGN_EN` undefined:
  - The SPLIT state is not compiled.
  - A crossing access writes nothing, returns rdata 0 and `rsp_err_o = 1`.
  - Latency is the same as a non-crossing access.

## Structure
- Package `dmem_pkg` holds:
  - `dmem_size_e` (SZ_B, SZ_H, SZ_W, SZ_D).
  - `dmem_state_e` (IDLE, SPLIT).
  - Function `byte_en(size, off, NB)`.
  - Function `load_extend(data, size, unsigned)`.
- Sub-module `dmem_bank`: one 8-bit-wide, DMEM_DEPTH-deep block RAM with write enable and a registered read. It is instantiated NB times in a generate loop.

## Test plan
Values below are for DATA_WIDTH = 32 with the macro defined unless stated.
- SW 0x010 data 0xDEADBEEF; LW 0x010 -> rdata 0xDEADBEEF, rsp_valid one cycle after accept.
- SB 0x013 data 0x80 -> LB 0x013 returns 0xFFFFFF80; LBU returns 0x00000080; LW 0x010 returns 0x80ADBEEF.
- SW 0x014 data 0x11223344; LW 0x012 -> rdata 0x334480AD, ready low for one cycle, response two cycles after accept.
- Without the macro, SW 0x012 data 0xCAFEF00D -> rsp_err_o = 1; memory at 0x010 and 0x014 is unchanged.
- SH 0xFFF data 0xA55A -> byte 0xFFF = 0x5A, byte 0x000 = 0xA5; LHU 0xFFF returns 0x0000A55A.
- rst_ni low during SPLIT of a crossing SW -> no rsp_valid; ready = 1 after release; only low-word lanes written.
